program_loader: RTL and testbench

//  Boot-time loader sitting upstream of the 16-bit multicycle CPU top. Accepts a

---
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: assembles a length-prefixed byte stream into 16-bit
// words, writes them to main memory from BASE_ADDR upward, then releases the CPU.
module program_loader #(
  parameter int unsigned        ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_count
);

  // Common width for comparing the word index against the 16-bit header.
  localparam int unsigned CW = (ADDR_W > 16) ? ADDR_W : 16;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_n_hi;
  logic [7:0]          r_word_hi;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_data;
  logic [15:0]         r_word_count;
  logic                r_mem_write;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;

  logic                w_ready;
  logic [15:0]         w_len;
  logic                w_len_zero;
  logic                w_len_big;
  logic                w_last;

  assign w_ready    = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
  assign w_len      = {r_n_hi, byte_in};
  assign w_len_zero = (w_len == 16'd0);
  assign w_len_big  = (32'(w_len) > MAX_WORDS);
  assign w_last     = ((CW'(r_idx) + CW'(1)) == CW'(r_word_count));

  // Every state that raises ready consumes on byte_valid alone, so the
  // next-state logic never has to look back at byte_ready.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_HI: begin
        if (byte_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (byte_valid) begin
          if (w_len_zero)     w_next = S_DONE;
          else if (w_len_big) w_next = S_ERR;
          else                w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (byte_valid) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (byte_valid) w_next = S_WRITE;
      end
      S_WRITE:  w_next = w_last ? S_DONE : S_DATA_HI;
      S_DONE:   w_next = S_DONE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LEN_HI;
      r_n_hi       <= '0;
      r_word_hi    <= '0;
      r_idx        <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_word_count <= '0;
      r_mem_write  <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LEN_HI:  if (byte_valid) r_n_hi <= byte_in;
        S_LEN_LO:  if (byte_valid) r_word_count <= w_len;
        S_DATA_HI: if (byte_valid) r_word_hi <= byte_in;
        S_DATA_LO: begin
          if (byte_valid) begin
            r_mem_data <= {r_word_hi, byte_in};
            r_mem_addr <= BASE_ADDR + r_idx;
          end
        end
        S_WRITE:   r_idx <= r_idx + ADDR_W'(1);
        default:   ;
      endcase
      // Strobe is registered from the next state so it spans exactly the WRITE cycle.
      r_mem_write <= (w_next == S_WRITE);
      if (w_next == S_DONE) begin
        r_done    <= 1'b1;
        r_cpu_rst <= 1'b0;
      end
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign byte_ready = w_ready & ~rst;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign cpu_rst    = r_cpu_rst;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven and randomized loads against a
// reference list of expected writes, plus timing/reset corner sequences.
module tb_program_loader;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        ready0, mw0, crst0, done0, err0;
  logic [15:0] addr0, data0, wc0;
  logic        ready1, mw1, crst1, done1, err1;
  logic [15:0] addr1, data1, wc1;

  program_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAX_WORDS(MAXW)) dut0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready0), .mem_write(mw0), .mem_addr(addr0), .mem_data(data0),
    .cpu_rst(crst0), .load_done(done0), .load_err(err0), .word_count(wc0));

  program_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .MAX_WORDS(MAXW)) dut1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready1), .mem_write(mw1), .mem_addr(addr1), .mem_data(data1),
    .cpu_rst(crst1), .load_done(done1), .load_err(err1), .word_count(wc1));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0]       n;
    int                nw;
    bit                rnd;
    logic [3:0][15:0]  w;
    int                gap;
    bit                exp_done;
    bit                exp_err;
  } vec_t;

  wr_t         wr0[$];
  wr_t         wr1[$];
  logic [7:0]  stim[$];
  logic [15:0] words[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        prev_mw0 = 1'b0;
  wr_t         mon_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Capture every write strobe and check handshake/strobe rules each cycle.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      prev_mw0 = 1'b0;
    end else begin
      if (mw0) begin
        mon_t.addr = addr0; mon_t.data = data0;
        wr0.push_back(mon_t);
        chk("strobe_single_cycle", {31'd0, prev_mw0}, 32'd0);
      end
      if (mw1) begin
        mon_t.addr = addr1; mon_t.data = data1;
        wr1.push_back(mon_t);
      end
      if (!done0 && !err0) chk("ready_low_only_in_write", {31'd0, ready0}, {31'd0, !mw0});
      prev_mw0 = mw0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr0.delete(); wr1.delete();
  endtask

  task automatic idle();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Offers stim[] in order; returns just after the edge accepting the last byte.
  task automatic send_stream(input int gap);
    int idx = 0;
    int cyc = 0;
    bit hold = 1'b0;
    while (idx < stim.size() && cyc < 4000) begin
      @(negedge clk);
      if (!hold) begin
        byte_valid = ($urandom_range(99) >= gap);
        byte_in    = byte_valid ? stim[idx] : 8'($urandom);
      end
      #1;
      hold = byte_valid && !ready0;
      if (byte_valid && ready0) idx++;
      @(posedge clk);
      cyc++;
    end
    chk("stream_all_bytes_accepted", idx, stim.size());
  endtask

  task automatic build(input vec_t v);
    logic [15:0] w;
    words.delete(); stim.delete();
    stim.push_back(v.n[15:8]);
    stim.push_back(v.n[7:0]);
    for (int i = 0; i < v.nw; i++) begin
      w = v.rnd ? 16'($urandom) : v.w[i];
      words.push_back(w);
      stim.push_back(w[15:8]);
      stim.push_back(w[7:0]);
    end
  endtask

  task automatic cmp_writes(input string nm, input wr_t q[$], input logic [15:0] base);
    logic [15:0] ea;
    chk({nm, "_count"}, q.size(), words.size());
    for (int i = 0; i < words.size(); i++) begin
      ea = base + 16'(i);
      if (i < q.size()) begin
        chk({nm, "_addr"}, {16'd0, q[i].addr}, {16'd0, ea});
        chk({nm, "_data"}, {16'd0, q[i].data}, {16'd0, words[i]});
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    build(v);
    do_reset();
    send_stream(v.gap);
    if (v.exp_err) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        byte_valid = 1'b1; byte_in = 8'($urandom);
        #1;
        chk("err_ready_low", {31'd0, ready0}, 32'd0);
      end
    end
    idle();
    repeat (2) @(negedge clk);
    chk("load_done", {31'd0, done0}, {31'd0, v.exp_done});
    chk("load_err", {31'd0, err0}, {31'd0, v.exp_err});
    chk("cpu_rst", {31'd0, crst0}, {31'd0, !v.exp_done});
    chk("word_count", {16'd0, wc0}, {16'd0, v.n});
    chk("ready_after_load", {31'd0, ready0}, 32'd0);
    chk("mem_write_idle", {31'd0, mw0}, 32'd0);
    chk("wrap_load_done", {31'd0, done1}, {31'd0, v.exp_done});
    cmp_writes("base0", wr0, 16'h0000);
    cmp_writes("baseFFFF", wr1, 16'hFFFF);
  endtask

  function automatic vec_t mk(input logic [15:0] n, input int nw, input bit rnd,
                              input logic [63:0] w, input int gap,
                              input bit ed, input bit ee);
    vec_t v;
    v.n = n; v.nw = nw; v.rnd = rnd; v.w = w; v.gap = gap;
    v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;

    tbl[0] = mk(16'd2,     2,   1'b0, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 0,  1'b1, 1'b0);
    tbl[1] = mk(16'd2,     2,   1'b0, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 50, 1'b1, 1'b0);
    tbl[2] = mk(16'd0,     0,   1'b0, 64'd0,                              0,  1'b1, 1'b0);
    tbl[3] = mk(16'd257,   0,   1'b0, 64'd0,                              0,  1'b0, 1'b1);
    tbl[4] = mk(16'd1,     1,   1'b0, {16'h0, 16'h0, 16'h0, 16'h8000},    30, 1'b1, 1'b0);
    tbl[5] = mk(16'd4,     4,   1'b0, {16'h0001, 16'h7FFF, 16'hFFFF, 16'h0000}, 20, 1'b1, 1'b0);
    tbl[6] = mk(16'd256,   256, 1'b1, 64'd0,                              10, 1'b1, 1'b0);
    tbl[7] = mk(16'hFFFF,  0,   1'b0, 64'd0,                              0,  1'b0, 1'b1);

    rst = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_rst", {31'd0, crst0}, 32'd1);
    chk("rst_mem_write", {31'd0, mw0}, 32'd0);
    chk("rst_mem_addr", {16'd0, addr0}, 32'd0);
    chk("rst_mem_data", {16'd0, data0}, 32'd0);
    chk("rst_load_done", {31'd0, done0}, 32'd0);
    chk("rst_load_err", {31'd0, err0}, 32'd0);
    chk("rst_word_count", {16'd0, wc0}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("ready_after_release", {31'd0, ready0}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv = mk(16'($urandom_range(12, 1)), 0, 1'b1, 64'd0, $urandom_range(70, 0), 1'b1, 1'b0);
      rv.nw = int'(rv.n);
      run_vec(rv);
    end

    // Final strobe lasts one cycle; cpu_rst falls at the edge after it.
    build(tbl[0]);
    do_reset();
    send_stream(0);
    #1;
    chk("t1_last_strobe", {31'd0, mw0}, 32'd1);
    chk("t1_last_addr", {16'd0, addr0}, 32'h0001);
    chk("t1_last_data", {16'd0, data0}, 32'hABCD);
    chk("t1_cpu_rst_held", {31'd0, crst0}, 32'd1);
    chk("t1_done_not_yet", {31'd0, done0}, 32'd0);
    @(posedge clk); #1;
    chk("t1_strobe_dropped", {31'd0, mw0}, 32'd0);
    chk("t1_cpu_released", {31'd0, crst0}, 32'd0);
    chk("t1_done", {31'd0, done0}, 32'd1);
    chk("t1_addr_hold", {16'd0, addr0}, 32'h0001);
    chk("t1_wc", {16'd0, wc0}, 32'd2);
    idle();

    // Zero-length image releases the CPU at the edge taking N_lo.
    build(tbl[2]);
    do_reset();
    send_stream(0);
    #1;
    chk("t3_cpu_released", {31'd0, crst0}, 32'd0);
    chk("t3_done", {31'd0, done0}, 32'd1);
    idle();
    repeat (3) @(negedge clk);
    chk("t3_no_writes", wr0.size(), 32'd0);

    // Asynchronous reset mid-load, then a fresh single-word load.
    stim.delete();
    stim.push_back(8'h00); stim.push_back(8'h02);
    stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
    do_reset();
    send_stream(0);
    #3;
    rst = 1'b1; byte_valid = 1'b0;
    #1;
    chk("t5_cpu_rst", {31'd0, crst0}, 32'd1);
    chk("t5_mem_write", {31'd0, mw0}, 32'd0);
    chk("t5_mem_data", {16'd0, data0}, 32'd0);
    chk("t5_wrap_addr", {16'd0, addr1}, 32'd0);
    chk("t5_word_count", {16'd0, wc0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr0.delete(); wr1.delete();
    #1;
    chk("t5_ready_release", {31'd0, ready0}, 32'd1);
    words.delete(); stim.delete();
    words.push_back(16'hBEEF);
    stim.push_back(8'h00); stim.push_back(8'h01);
    stim.push_back(8'hBE); stim.push_back(8'hEF);
    send_stream(20);
    idle();
    repeat (2) @(negedge clk);
    chk("t5_done", {31'd0, done0}, 32'd1);
    cmp_writes("t5_base0", wr0, 16'h0000);
    cmp_writes("t5_baseFFFF", wr1, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
